// File: rtl/llki_tl_host_arb.sv
// llki_tl_host_arb: N-to-1 TL-UL host arbiter sharing one LLKI-side device port.
// The A channel is granted round-robin (combinational, 0-cycle) with a valid-stability
// lock. Each accepted request pushes the winning host index into an in-order tag FIFO
// so the matching D response is steered back to the host that issued it.
// TL field widths default to the top_pkg values (TL_AW/TL_DW/TL_DBW/TL_AIW/TL_SZW).
// Build option: define LLKI_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins,
// rr_ptr held at 0); lock and FIFO behaviour are identical in both builds.

// Protocol checker: a D beat with no outstanding tag, and a push into a full FIFO.
module llki_tl_host_arb_chk (
  input logic clk_i,
  input logic rst_ni,
  input logic dev_d_valid_i,
  input logic fifo_empty,
  input logic fifo_full,
  input logic a_hs
);
  a_no_orphan_d: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(dev_d_valid_i && fifo_empty));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(a_hs && fifo_full));
endmodule

module llki_tl_host_arb #(
  parameter int N_HOSTS = 2,
  parameter int MAX_OUT = 4,
  parameter int TL_AW   = 32,
  parameter int TL_DW   = 32,
  parameter int TL_DBW  = 4,
  parameter int TL_AIW  = 8,
  parameter int TL_SZW  = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_HOSTS-1:0]        h_a_valid_i,
  output logic [N_HOSTS-1:0]        h_a_ready_o,
  input  logic [N_HOSTS*3-1:0]      h_a_opcode_i,
  input  logic [N_HOSTS*TL_SZW-1:0] h_a_size_i,
  input  logic [N_HOSTS*TL_AIW-1:0] h_a_source_i,
  input  logic [N_HOSTS*TL_AW-1:0]  h_a_address_i,
  input  logic [N_HOSTS*TL_DBW-1:0] h_a_mask_i,
  input  logic [N_HOSTS*TL_DW-1:0]  h_a_data_i,
  output logic [N_HOSTS-1:0]        h_d_valid_o,
  input  logic [N_HOSTS-1:0]        h_d_ready_i,
  output logic [2:0]                h_d_opcode_o,
  output logic [TL_AIW-1:0]         h_d_source_o,
  output logic [TL_DW-1:0]          h_d_data_o,
  output logic                      h_d_error_o,
  output logic                      dev_a_valid_o,
  input  logic                      dev_a_ready_i,
  output logic [2:0]                dev_a_opcode_o,
  output logic [TL_SZW-1:0]         dev_a_size_o,
  output logic [TL_AIW-1:0]         dev_a_source_o,
  output logic [TL_AW-1:0]          dev_a_address_o,
  output logic [TL_DBW-1:0]         dev_a_mask_o,
  output logic [TL_DW-1:0]          dev_a_data_o,
  input  logic                      dev_d_valid_i,
  output logic                      dev_d_ready_o,
  input  logic [2:0]                dev_d_opcode_i,
  input  logic [TL_AIW-1:0]         dev_d_source_i,
  input  logic [TL_DW-1:0]          dev_d_data_i,
  input  logic                      dev_d_error_i,
  output logic                      busy_o
);

  localparam int IDXW = $clog2(N_HOSTS);
  localparam int PTRW = $clog2(MAX_OUT);
  localparam int CNTW = PTRW + 1;

  logic [IDXW-1:0] rr_ptr_r;
  logic [IDXW-1:0] lock_idx_r;
  logic            locked_r;
  logic [IDXW-1:0] tag_mem_r [MAX_OUT];
  logic [PTRW-1:0] wr_ptr_r;
  logic [PTRW-1:0] rd_ptr_r;
  logic [CNTW-1:0] count_r;

  logic [IDXW-1:0] winner_s;
  logic            winner_valid_s;
  logic [IDXW-1:0] next_rr_s;
  logic [IDXW-1:0] head_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;
  logic            a_hs_s;
  logic            d_hs_s;

  // Per-host A payload unpacked so the granted host can be selected by index.
  logic [2:0]        a_opc_arr_s  [N_HOSTS];
  logic [TL_SZW-1:0] a_size_arr_s [N_HOSTS];
  logic [TL_AIW-1:0] a_src_arr_s  [N_HOSTS];
  logic [TL_AW-1:0]  a_addr_arr_s [N_HOSTS];
  logic [TL_DBW-1:0] a_mask_arr_s [N_HOSTS];
  logic [TL_DW-1:0]  a_data_arr_s [N_HOSTS];

  for (genvar g = 0; g < N_HOSTS; g++) begin : g_unpack
    assign a_opc_arr_s[g]  = h_a_opcode_i[g*3 +: 3];
    assign a_size_arr_s[g] = h_a_size_i[g*TL_SZW +: TL_SZW];
    assign a_src_arr_s[g]  = h_a_source_i[g*TL_AIW +: TL_AIW];
    assign a_addr_arr_s[g] = h_a_address_i[g*TL_AW +: TL_AW];
    assign a_mask_arr_s[g] = h_a_mask_i[g*TL_DBW +: TL_DBW];
    assign a_data_arr_s[g] = h_a_data_i[g*TL_DW +: TL_DW];
  end

  assign fifo_full_s  = (count_r == CNTW'(MAX_OUT));
  assign fifo_empty_s = (count_r == {CNTW{1'b0}});
  assign head_s       = tag_mem_r[rd_ptr_r];
  assign busy_o       = ~fifo_empty_s;

  // Winner select: locked host if a request is pending, else first requester at/after rr_ptr.
  always_comb begin
    int              cand_v;
    logic [IDXW-1:0] cand_s;
    winner_s       = rr_ptr_r;
    winner_valid_s = 1'b0;
    cand_v         = 0;
    cand_s         = {IDXW{1'b0}};
    if (locked_r) begin
      winner_s       = lock_idx_r;
      winner_valid_s = h_a_valid_i[lock_idx_r];
    end else begin
      // Scan from farthest to nearest so the nearest requester is written last.
      for (int k = N_HOSTS - 1; k >= 0; k--) begin
        cand_v         = int'(rr_ptr_r) + k;
        cand_v         = (cand_v >= N_HOSTS) ? (cand_v - N_HOSTS) : cand_v;
        cand_s         = IDXW'(cand_v);
        winner_s       = h_a_valid_i[cand_s] ? cand_s : winner_s;
        winner_valid_s = h_a_valid_i[cand_s] | winner_valid_s;
      end
    end
  end

`ifdef LLKI_ARB_FIXED_PRIO_EN
  assign next_rr_s = {IDXW{1'b0}};
`else
  assign next_rr_s = (winner_s == IDXW'(N_HOSTS - 1)) ? {IDXW{1'b0}} : (winner_s + 1'b1);
`endif

  assign dev_a_valid_o   = winner_valid_s & ~fifo_full_s;
  assign dev_a_opcode_o  = a_opc_arr_s[winner_s];
  assign dev_a_size_o    = a_size_arr_s[winner_s];
  assign dev_a_source_o  = a_src_arr_s[winner_s];
  assign dev_a_address_o = a_addr_arr_s[winner_s];
  assign dev_a_mask_o    = a_mask_arr_s[winner_s];
  assign dev_a_data_o    = a_data_arr_s[winner_s];
  assign a_hs_s          = dev_a_valid_o & dev_a_ready_i;

  assign dev_d_ready_o = h_d_ready_i[head_s] & ~fifo_empty_s;
  assign d_hs_s        = dev_d_valid_i & dev_d_ready_o;
  assign h_d_opcode_o  = dev_d_opcode_i;
  assign h_d_source_o  = dev_d_source_i;
  assign h_d_data_o    = dev_d_data_i;
  assign h_d_error_o   = dev_d_error_i;

  // Per-host ready/valid steering: only the A winner and the D head host see activity.
  always_comb begin
    h_a_ready_o           = {N_HOSTS{1'b0}};
    h_d_valid_o           = {N_HOSTS{1'b0}};
    h_a_ready_o[winner_s] = winner_valid_s & dev_a_ready_i & ~fifo_full_s;
    h_d_valid_o[head_s]   = dev_d_valid_i & ~fifo_empty_s;
  end

  // Arbitration state: advance rr_ptr on handshake, hold grant while a request stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_r   <= {IDXW{1'b0}};
      lock_idx_r <= {IDXW{1'b0}};
      locked_r   <= 1'b0;
    end else if (a_hs_s) begin
      rr_ptr_r <= next_rr_s;
      locked_r <= 1'b0;
    end else if (dev_a_valid_o && !dev_a_ready_i) begin
      lock_idx_r <= winner_s;
      locked_r   <= 1'b1;
    end else begin
      locked_r <= locked_r;
    end
  end

  // In-order tag FIFO: push winner on A handshake, pop head on D handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= {PTRW{1'b0}};
      rd_ptr_r <= {PTRW{1'b0}};
      count_r  <= {CNTW{1'b0}};
      for (int i = 0; i < MAX_OUT; i++) begin
        tag_mem_r[i] <= {IDXW{1'b0}};
      end
    end else begin
      if (a_hs_s) begin
        tag_mem_r[wr_ptr_r] <= winner_s;
        wr_ptr_r            <= wr_ptr_r + 1'b1;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (d_hs_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      if (a_hs_s && !d_hs_s) begin
        count_r <= count_r + 1'b1;
      end else if (!a_hs_s && d_hs_s) begin
        count_r <= count_r - 1'b1;
      end else begin
        count_r <= count_r;
      end
    end
  end

  llki_tl_host_arb_chk u_chk (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .dev_d_valid_i (dev_d_valid_i),
    .fifo_empty    (fifo_empty_s),
    .fifo_full     (fifo_full_s),
    .a_hs          (a_hs_s)
  );

endmodule

// File: tb/tb_llki_tl_host_arb.sv
// Self-checking bench for llki_tl_host_arb (N_HOSTS=2, MAX_OUT=4).
// Define LLKI_ARB_FIXED_PRIO_EN for both bench and RTL to exercise the fixed-priority build.
`timescale 1ns/1ps
module tb_llki_tl_host_arb;
  localparam int N = 2, MO = 4, AW = 32, DW = 32, DBW = 4, AIW = 8, SZW = 2;
`ifdef LLKI_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] a_valid = '0, a_ready, d_valid, d_ready = '0;
  logic [N*3-1:0] a_opcode;
  logic [N*SZW-1:0] a_size;
  logic [N*AIW-1:0] a_source;
  logic [N*AW-1:0] a_address;
  logic [N*DBW-1:0] a_mask;
  logic [N*DW-1:0] a_data;
  logic [2:0] p_opc [N];
  logic [SZW-1:0] p_size [N];
  logic [AIW-1:0] p_src [N];
  logic [AW-1:0] p_addr [N];
  logic [DBW-1:0] p_mask [N];
  logic [DW-1:0] p_data [N];
  logic [2:0] hd_opcode, dev_a_opcode, dev_d_opcode = 3'd1;
  logic [AIW-1:0] hd_source, dev_a_source, dev_d_source = 8'h05;
  logic [DW-1:0] hd_data, dev_a_data, dev_d_data = 32'h0;
  logic hd_error, dev_d_error = 1'b0;
  logic dev_a_valid, dev_a_ready = 1'b0, dev_d_valid = 1'b0, dev_d_ready, busy;
  logic [SZW-1:0] dev_a_size;
  logic [AW-1:0] dev_a_address;
  logic [DBW-1:0] dev_a_mask;

  // Pack per-host payload fields into the flat DUT ports.
  always_comb begin
    a_opcode = '0; a_size = '0; a_source = '0; a_address = '0; a_mask = '0; a_data = '0;
    for (int h = 0; h < N; h++) begin
      a_opcode[h*3 +: 3] = p_opc[h];
      a_size[h*SZW +: SZW] = p_size[h];
      a_source[h*AIW +: AIW] = p_src[h];
      a_address[h*AW +: AW] = p_addr[h];
      a_mask[h*DBW +: DBW] = p_mask[h];
      a_data[h*DW +: DW] = p_data[h];
    end
  end

  llki_tl_host_arb #(.N_HOSTS(N), .MAX_OUT(MO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .h_a_valid_i(a_valid), .h_a_ready_o(a_ready), .h_a_opcode_i(a_opcode),
    .h_a_size_i(a_size), .h_a_source_i(a_source), .h_a_address_i(a_address),
    .h_a_mask_i(a_mask), .h_a_data_i(a_data),
    .h_d_valid_o(d_valid), .h_d_ready_i(d_ready), .h_d_opcode_o(hd_opcode),
    .h_d_source_o(hd_source), .h_d_data_o(hd_data), .h_d_error_o(hd_error),
    .dev_a_valid_o(dev_a_valid), .dev_a_ready_i(dev_a_ready), .dev_a_opcode_o(dev_a_opcode),
    .dev_a_size_o(dev_a_size), .dev_a_source_o(dev_a_source), .dev_a_address_o(dev_a_address),
    .dev_a_mask_o(dev_a_mask), .dev_a_data_o(dev_a_data),
    .dev_d_valid_i(dev_d_valid), .dev_d_ready_o(dev_d_ready), .dev_d_opcode_i(dev_d_opcode),
    .dev_d_source_i(dev_d_source), .dev_d_data_i(dev_d_data), .dev_d_error_i(dev_d_error),
    .busy_o(busy)
  );

  int checks = 0, errors = 0;

  // Reference model: outstanding host indices in issue order, next-preferred host, lock.
  int m_q[$];
  int m_rr = 0;
  bit m_locked = 1'b0;
  int m_lock_idx = 0;
  int e_w, e_head;
  bit e_wv, e_a_valid, e_d_ready, e_busy;
  logic [N-1:0] e_a_ready, e_d_valid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete(); m_rr = 0; m_locked = 1'b0; m_lock_idx = 0;
  endtask

  task automatic model_eval();
    bit full, empty;
    full = (m_q.size() == MO);
    empty = (m_q.size() == 0);
    e_wv = 1'b0; e_w = 0; e_head = 0;
    if (m_locked) begin
      e_w = m_lock_idx; e_wv = a_valid[e_w];
    end else begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (!e_wv && a_valid[i]) begin e_w = i; e_wv = 1'b1; end
      end
    end
    e_a_valid = e_wv && !full;
    e_a_ready = '0;
    if (e_wv && dev_a_ready && !full) e_a_ready[e_w] = 1'b1;
    e_d_valid = '0; e_d_ready = 1'b0;
    if (!empty) begin
      e_head = m_q[0];
      if (dev_d_valid) e_d_valid[e_head] = 1'b1;
      e_d_ready = d_ready[e_head];
    end
    e_busy = !empty;
  endtask

  task automatic model_update();
    if (dev_d_valid && e_d_ready) void'(m_q.pop_front());
    if (e_a_valid && dev_a_ready) begin
      m_q.push_back(e_w);
      m_locked = 1'b0;
      m_rr = FIXED ? 0 : (e_w + 1) % N;
    end else if (e_a_valid && !dev_a_ready) begin
      m_locked = 1'b1; m_lock_idx = e_w;
    end
  endtask

  // One cycle: inputs already set at negedge; compare outputs, clock, advance model.
  task automatic step(input string tag);
    #1;
    model_eval();
    chk({tag, ".dev_a_valid"}, dev_a_valid, e_a_valid);
    chk({tag, ".h_a_ready"}, a_ready, e_a_ready);
    chk({tag, ".h_d_valid"}, d_valid, e_d_valid);
    chk({tag, ".dev_d_ready"}, dev_d_ready, e_d_ready);
    chk({tag, ".busy"}, busy, e_busy);
    chk({tag, ".h_d_data"}, hd_data, dev_d_data);
    chk({tag, ".h_d_source"}, hd_source, dev_d_source);
    if (e_a_valid) begin
      chk({tag, ".dev_a_address"}, dev_a_address, p_addr[e_w]);
      chk({tag, ".dev_a_opcode"}, dev_a_opcode, p_opc[e_w]);
      chk({tag, ".dev_a_source"}, dev_a_source, p_src[e_w]);
      chk({tag, ".dev_a_data"}, dev_a_data, p_data[e_w]);
      chk({tag, ".dev_a_mask"}, dev_a_mask, p_mask[e_w]);
      chk({tag, ".dev_a_size"}, dev_a_size, p_size[e_w]);
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] av, input logic ar, input logic dv, input logic [1:0] dr);
    a_valid = av; dev_a_ready = ar; dev_d_valid = dv; d_ready = dr;
  endtask

  typedef struct {
    logic [1:0] av; logic ar; logic dv; logic [1:0] dr;
    logic xav; logic [1:0] xar; logic [1:0] xdv; logic xdr; logic xbusy;
  } vec_t;
  vec_t vt[9];

  initial begin
    for (int h = 0; h < N; h++) begin
      p_opc[h] = 3'd4; p_size[h] = 2'd2; p_src[h] = 8'h05;
      p_addr[h] = 32'h1000 * (h + 1); p_mask[h] = 4'hF; p_data[h] = 32'hA000 + h;
    end
    // Inputs, then expected dev_a_valid, h_a_ready, h_d_valid, dev_d_ready, busy.
    vt[0] = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0};
    vt[1] = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 2'b10, 2'b00, 1'b1, 1'b1};
    vt[2] = '{2'b00, 1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1};
    vt[3] = '{2'b01, 1'b0, 1'b1, 2'b01, 1'b1, 2'b00, 2'b10, 1'b0, 1'b1};
    vt[4] = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 2'b01, 2'b10, 1'b1, 1'b1};
    vt[5] = '{2'b10, 1'b1, 1'b0, 2'b00, 1'b1, 2'b10, 2'b00, 1'b0, 1'b1};
    vt[6] = '{2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1};
    vt[7] = '{2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 2'b10, 1'b1, 1'b1};
    vt[8] = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};

    // Reset: hold low with idle inputs, release, check first cycle outputs.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("reset.dev_a_valid", dev_a_valid, 1'b0);
    chk("reset.h_a_ready", a_ready, 2'b00);
    chk("reset.h_d_valid", d_valid, 2'b00);
    chk("reset.dev_d_ready", dev_d_ready, 1'b0);
    chk("reset.busy", busy, 1'b0);
    step("reset");

`ifndef LLKI_ARB_FIXED_PRIO_EN
    // Directed vector table from reset state (round-robin build).
    for (int r = 0; r < 9; r++) begin
      drive(vt[r].av, vt[r].ar, vt[r].dv, vt[r].dr);
      #1;
      chk($sformatf("vec%0d.dev_a_valid", r), dev_a_valid, vt[r].xav);
      chk($sformatf("vec%0d.h_a_ready", r), a_ready, vt[r].xar);
      chk($sformatf("vec%0d.h_d_valid", r), d_valid, vt[r].xdv);
      chk($sformatf("vec%0d.dev_d_ready", r), dev_d_ready, vt[r].xdr);
      chk($sformatf("vec%0d.busy", r), busy, vt[r].xbusy);
      step($sformatf("vec%0d", r));
    end
`endif

    // Fairness: both hosts request continuously; RR alternates, fixed priority stays on 0.
    for (int k = 0; k < 4; k++) begin
      logic [1:0] g;
      g = FIXED ? 2'b01 : ((k % 2 == 0) ? 2'b01 : 2'b10);
      drive(2'b11, 1'b1, 1'b0, 2'b11);
      #1; chk($sformatf("fair%0d.grant", k), a_ready, g);
      step("fair");
    end
    for (int k = 0; k < 4; k++) begin
      logic [1:0] g;
      g = FIXED ? 2'b01 : ((k % 2 == 0) ? 2'b01 : 2'b10);
      drive(2'b00, 1'b0, 1'b1, 2'b11);
      #1; chk($sformatf("fair%0d.dret", k), d_valid, g);
      step("fair_d");
    end

    // Lock: host1 stalls, host0 joins; grant must stay on host1 until handshake.
    drive(2'b10, 1'b0, 1'b0, 2'b00);
    #1; chk("lock0.addr", dev_a_address, 32'h2000);
    step("lock0");
    for (int k = 1; k < 3; k++) begin
      drive(2'b11, 1'b0, 1'b0, 2'b00);
      #1; chk($sformatf("lock%0d.addr", k), dev_a_address, 32'h2000);
      chk($sformatf("lock%0d.ready", k), a_ready, 2'b00);
      step("lock");
    end
    drive(2'b11, 1'b1, 1'b0, 2'b00);
    #1; chk("lock3.ready", a_ready, 2'b10);
    step("lock3");
    #1; chk("lock4.ready", a_ready, 2'b01);
    chk("lock4.addr", dev_a_address, 32'h1000);
    step("lock4");
    drive(2'b00, 1'b0, 1'b1, 2'b11);
    #1; chk("lockd0.dv", d_valid, 2'b10);
    step("lockd0");
    #1; chk("lockd1.dv", d_valid, 2'b01);
    step("lockd1");

    // Full: four Gets fill the FIFO, fifth is held until a pop has registered.
    for (int k = 0; k < 4; k++) begin
      drive(2'b01, 1'b1, 1'b0, 2'b00);
      step("fill");
    end
    #1; chk("full.ready", a_ready, 2'b00);
    chk("full.dev_a_valid", dev_a_valid, 1'b0);
    step("full");
    drive(2'b01, 1'b1, 1'b1, 2'b01);
    #1; chk("full_pop.ready", a_ready, 2'b00);
    chk("full_pop.dev_d_ready", dev_d_ready, 1'b1);
    step("full_pop");
    drive(2'b01, 1'b1, 1'b0, 2'b00);
    #1; chk("full_after.ready", a_ready, 2'b01);
    chk("full_after.busy", busy, 1'b1);
    step("full_after");

    // D backpressure: head host not ready for 5 cycles, no pop, other host untouched.
    for (int k = 0; k < 5; k++) begin
      drive(2'b00, 1'b0, 1'b1, 2'b10);
      #1; chk($sformatf("bp%0d.dev_d_ready", k), dev_d_ready, 1'b0);
      chk($sformatf("bp%0d.h_d_valid", k), d_valid, 2'b01);
      step("bp");
    end
    for (int k = 0; k < 4; k++) begin
      drive(2'b00, 1'b0, 1'b1, 2'b11);
      step("drain");
    end
    drive(2'b00, 1'b0, 1'b0, 2'b00);
    #1; chk("drain.busy", busy, 1'b0);
    step("idle");

    // Randomized traffic against the queue model; locked host keeps valid and payload.
    for (int c = 0; c < 400; c++) begin
      for (int h = 0; h < N; h++) begin
        if (m_locked && m_lock_idx == h) begin
          a_valid[h] = 1'b1;
        end else begin
          a_valid[h] = 1'($urandom_range(0, 1));
          p_opc[h] = 3'($urandom_range(0, 4));
          p_addr[h] = $urandom;
          p_data[h] = $urandom;
          p_mask[h] = 4'($urandom);
          p_src[h] = 8'($urandom_range(0, 3));
          p_size[h] = 2'($urandom);
        end
      end
      dev_a_ready = 1'($urandom_range(0, 1));
      d_ready = 2'($urandom);
      dev_d_valid = (m_q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      dev_d_data = $urandom;
      dev_d_source = 8'($urandom);
      step("rnd");
    end

    // Reset mid-transaction: outstanding tags discarded immediately.
    drive(2'b01, 1'b1, 1'b0, 2'b00);
    step("pre_rst");
    step("pre_rst");
    drive(2'b00, 1'b0, 1'b0, 2'b00);
    rst_n = 1'b0;
    #1; chk("midrst.busy", busy, 1'b0);
    chk("midrst.dev_a_valid", dev_a_valid, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
